// File: rtl/glyph_renderer.sv
// Glyph ROM reader: maps raster position to ROM rows and serialises the row into a positioned two-colour glyph.
// Two pix_en ticks from hcount/vcount/syncs to rgb/syncs. pix_en low stalls the pipeline; the position latch still loads on frame_start.
module glyph_renderer #(
  parameter int GLYPH_W = 64,
  parameter int GLYPH_H = 64,
  parameter int ADDR_W  = 6,
  parameter int CNT_W   = 10,
  parameter int RGB_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [CNT_W-1:0]   hcount,
  input  logic [CNT_W-1:0]   vcount,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               frame_start,
  input  logic [CNT_W-1:0]   glyph_x,
  input  logic [CNT_W-1:0]   glyph_y,
  input  logic [RGB_W-1:0]   fg_color,
  input  logic [RGB_W-1:0]   bg_color,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic [RGB_W-1:0]   rgb,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               glyph_hit
);

  localparam int COL_W = $clog2(GLYPH_W);
  localparam logic [CNT_W:0] GW_EXT = (CNT_W+1)'(GLYPH_W);
  localparam logic [CNT_W:0] GH_EXT = (CNT_W+1)'(GLYPH_H);

  logic [CNT_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              in_box_q, in_box_d;
  logic              von1_q, von1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              glyph_hit_q, glyph_hit_d;

  logic [CNT_W:0]    dx, dy;
  logic              in_x, in_y;
  logic [COL_W-1:0]  bit_idx;
  logic              pix_bit;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (frame_start) begin
      pos_x_d = glyph_x;
      pos_y_d = glyph_y;
    end

    // Differences are one bit wider than the counters: a position left of or
    // above the glyph wraps past 2^CNT_W, so a single compare covers both bounds
    // and a glyph crossing the counter limit is clipped rather than wrapped.
    dx   = {1'b0, hcount} - {1'b0, pos_x_q};
    dy   = {1'b0, vcount} - {1'b0, pos_y_q};
    in_x = dx < GW_EXT;
    in_y = dy < GH_EXT;

    bit_idx = COL_W'(GLYPH_W - 1) - col_q;
    pix_bit = rom_data[bit_idx];

    rom_address_d = rom_address_q;
    col_d         = col_q;
    in_box_d      = in_box_q;
    von1_d        = von1_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    hs2_d         = hs2_q;
    vs2_d         = vs2_q;
    rgb_d         = rgb_q;
    glyph_hit_d   = glyph_hit_q;

    if (pix_en) begin
      rom_address_d = in_y ? dy[ADDR_W-1:0] : '0;
      col_d         = dx[COL_W-1:0];
      in_box_d      = in_x & in_y;
      von1_d        = video_on;
      hs1_d         = hsync_in;
      vs1_d         = vsync_in;

      rgb_d = '0;
      if (von1_q && in_box_q)
        rgb_d = pix_bit ? fg_color : bg_color;
      glyph_hit_d = von1_q & in_box_q & pix_bit;
      hs2_d       = hs1_q;
      vs2_d       = vs1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      rom_address_q <= '0;
      col_q         <= '0;
      in_box_q      <= 1'b0;
      von1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      rgb_q         <= '0;
      glyph_hit_q   <= 1'b0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      rom_address_q <= rom_address_d;
      col_q         <= col_d;
      in_box_q      <= in_box_d;
      von1_q        <= von1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      rgb_q         <= rgb_d;
      glyph_hit_q   <= glyph_hit_d;
    end
  end

  assign rom_address = rom_address_q;
  assign rgb         = rgb_q;
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign glyph_hit   = glyph_hit_q;

endmodule

// File: tb/tb_glyph_renderer.sv
// Directed bench for glyph_renderer with a behavioural 64x64 ROM.
module tb_glyph_renderer;
  localparam int CNT_W = 10;
  localparam int RGB_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_en;
  logic [CNT_W-1:0]  hcount, vcount;
  logic              video_on, hsync_in, vsync_in, frame_start;
  logic [CNT_W-1:0]  glyph_x, glyph_y;
  logic [RGB_W-1:0]  fg_color, bg_color;
  logic [5:0]        rom_address;
  logic [63:0]       rom_data;
  logic [RGB_W-1:0]  rgb;
  logic              hsync_out, vsync_out, glyph_hit;

  logic [63:0] rom_mem [64];
  logic [63:0] row13;
  int checks = 0;
  int errors = 0;
  int exp_px, exp_py;

  always #5 clk = ~clk;
  assign rom_data = rom_mem[rom_address];

  glyph_renderer dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_start(frame_start), .glyph_x(glyph_x), .glyph_y(glyph_y),
    .fg_color(fg_color), .bg_color(bg_color), .rom_address(rom_address),
    .rom_data(rom_data), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .glyph_hit(glyph_hit)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RGB_W-1:0] exp_rgb(input int h, input int v, input logic von);
    int c, r;
    if (!von) return '0;
    if (h < exp_px || h >= exp_px + 64 || v < exp_py || v >= exp_py + 64) return '0;
    c = h - exp_px;
    r = v - exp_py;
    return rom_mem[r][63-c] ? fg_color : bg_color;
  endfunction

  // Each step's output corresponds to the hcount applied on the previous step.
  task automatic scan(input int h0, input int n, input string tag);
    int prev_h;
    for (int i = 0; i < n; i++) begin
      hcount = CNT_W'((h0 + i) % 1024);
      step();
      if (i > 0) begin
        chk({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb(prev_h, int'(vcount), video_on)));
        chk({tag, "_hit"}, 32'(glyph_hit),
            32'(exp_rgb(prev_h, int'(vcount), video_on) == fg_color));
      end
      prev_h = (h0 + i) % 1024;
    end
  endtask

  task automatic latch_pos(input int x, input int y);
    glyph_x = CNT_W'(x);
    glyph_y = CNT_W'(y);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    exp_px = x;
    exp_py = y;
  endtask

  initial begin
    row13 = {23'h7FFFFF, 17'h0, 24'hFFFFFF};
    for (int r = 0; r < 64; r++) rom_mem[r] = 64'hF0F0_F0F0_F0F0_F0F0 ^ 64'(r);
    rom_mem[13] = row13;

    rst = 1'b1; pix_en = 1'b1; hcount = '0; vcount = '0; video_on = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; frame_start = 1'b0;
    glyph_x = '0; glyph_y = '0; fg_color = 12'hABC; bg_color = 12'h123;
    exp_px = 0; exp_py = 0;

    // Reset values before any clock edge and while clocking in reset
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'h1);
    chk("rst_vs", 32'(vsync_out), 32'h1);
    chk("rst_addr", 32'(rom_address), 32'h0);
    chk("rst_hit", 32'(glyph_hit), 32'h0);
    step();
    chk("rst_hs_clk", 32'(hsync_out), 32'h1);
    rst = 1'b0;

    // Sync delay of two ticks
    hsync_in = 1'b0; vsync_in = 1'b1;
    step();
    chk("sync_t1_hs", 32'(hsync_out), 32'h1);
    step();
    chk("sync_t2_hs", 32'(hsync_out), 32'h0);
    chk("sync_t2_vs", 32'(vsync_out), 32'h1);
    hsync_in = 1'b1; vsync_in = 1'b0;
    step();
    chk("sync_t3_hs", 32'(hsync_out), 32'h0);
    step();
    chk("sync_t4_hs", 32'(hsync_out), 32'h1);
    chk("sync_t4_vs", 32'(vsync_out), 32'h0);
    vsync_in = 1'b1;

    // Glyph at (100,50), line 63 uses ROM row 13
    latch_pos(100, 50);
    vcount = 10'd63;
    hcount = 10'd100;
    step();
    chk("row_addr", 32'(rom_address), 32'd13);
    scan(96, 72, "pos100");

    // Mid-frame glyph_x change is ignored until frame_start
    glyph_x = 10'd300;
    scan(296, 10, "nolatch");
    scan(98, 8, "nolatch_old");

    // frame_start coinciding with pix_en: stage 1 sees old position this tick
    hcount = 10'd300; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    hcount = 10'd300;
    step();
    chk("fs_old_pos", 32'(rgb), 32'h0);
    exp_px = 300;
    hcount = 10'd301;
    step();
    chk("fs_new_pos", 32'(rgb), 32'(fg_color));
    scan(300, 70, "pos300");
    scan(96, 10, "pos300_old_x");

    // Right-edge clipping: nothing reappears at low hcount
    latch_pos(1000, 50);
    scan(990, 75, "clip");

    // pix_en 1-0-0-1 stall
    latch_pos(100, 50);
    hcount = 10'd122;
    step();
    hcount = 10'd123;
    step();
    chk("stall_pre", 32'(rgb), 32'(fg_color));
    pix_en = 1'b0; hsync_in = 1'b0; hcount = 10'd124;
    step();
    chk("stall_hold1", 32'(rgb), 32'(fg_color));
    chk("stall_hs1", 32'(hsync_out), 32'h1);
    hcount = 10'd125;
    step();
    chk("stall_hold2", 32'(rgb), 32'(fg_color));
    chk("stall_addr", 32'(rom_address), 32'd13);
    pix_en = 1'b1; hcount = 10'd126;
    step();
    chk("stall_resume", 32'(rgb), 32'(bg_color));
    chk("stall_hs2", 32'(hsync_out), 32'h1);
    hcount = 10'd127;
    step();
    chk("stall_next", 32'(rgb), 32'(bg_color));
    chk("stall_hs3", 32'(hsync_out), 32'h0);
    hsync_in = 1'b1;
    step();
    step();

    // video_on low inside the box blanks output but syncs still travel
    video_on = 1'b0; hsync_in = 1'b0;
    scan(100, 6, "blank");
    chk("blank_hs", 32'(hsync_out), 32'h0);
    hsync_in = 1'b1;
    step();
    chk("blank_hs_t1", 32'(hsync_out), 32'h0);
    step();
    chk("blank_hs_t2", 32'(hsync_out), 32'h1);
    video_on = 1'b1;

    // Reset mid-line with foreground on the output
    scan(100, 5, "pre_rst");
    chk("pre_rst_fg", 32'(rgb), 32'(fg_color));
    hsync_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_hit", 32'(glyph_hit), 32'h0);
    chk("mid_rst_hs", 32'(hsync_out), 32'h1);
    chk("mid_rst_addr", 32'(rom_address), 32'h0);
    step();
    rst = 1'b0; hsync_in = 1'b1;
    exp_px = 0; exp_py = 0;
    vcount = 10'd13;
    hcount = 10'd0;
    step();
    chk("post_rst_t1", 32'(rgb), 32'h0);
    chk("post_rst_addr", 32'(rom_address), 32'd13);
    hcount = 10'd1;
    step();
    chk("post_rst_t2", 32'(rgb), 32'(fg_color));
    scan(2, 66, "pos0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
